// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8-bit UART receive path. 16x oversampling, 1 start, 8 data
//               (LSB first), 1 parity, 1 stop bit. Each byte is presented
//               with a one-cycle valid strobe and parity/framing flags.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter bit          PARITY_EVEN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  // Baud rates addressed by baud_select, shared with the transmitter.
  localparam int unsigned BAUD_0 = 300;
  localparam int unsigned BAUD_1 = 1200;
  localparam int unsigned BAUD_2 = 4800;
  localparam int unsigned BAUD_3 = 9600;
  localparam int unsigned BAUD_4 = 19200;
  localparam int unsigned BAUD_5 = 38400;
  localparam int unsigned BAUD_6 = 57600;
  localparam int unsigned BAUD_7 = 115200;

  // Clocks per sample tick, rounded to nearest.
  localparam int unsigned DIV_0 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_0) / (OVERSAMPLE * BAUD_0);
  localparam int unsigned DIV_1 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_1) / (OVERSAMPLE * BAUD_1);
  localparam int unsigned DIV_2 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_2) / (OVERSAMPLE * BAUD_2);
  localparam int unsigned DIV_3 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_3) / (OVERSAMPLE * BAUD_3);
  localparam int unsigned DIV_4 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_4) / (OVERSAMPLE * BAUD_4);
  localparam int unsigned DIV_5 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_5) / (OVERSAMPLE * BAUD_5);
  localparam int unsigned DIV_6 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_6) / (OVERSAMPLE * BAUD_6);
  localparam int unsigned DIV_7 = (CLK_FREQ + (OVERSAMPLE / 2) * BAUD_7) / (OVERSAMPLE * BAUD_7);

  // Sample index of the mid-bit point for the start bit and for full bits.
  localparam logic [3:0] START_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);
  localparam logic       ODD_FLIP    = PARITY_EVEN ? 1'b0 : 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Keep the divider inside the 15-bit counter range and never zero.
  function automatic logic [14:0] clamp_div(input int unsigned d);
    if (d == 0) begin
      return 15'd1;
    end else if (d > 32'd32767) begin
      return 15'h7fff;
    end else begin
      return d[14:0];
    end
  endfunction

  state_t      state_q,      state_d;
  logic        rx_meta_q,    rx_meta_d;
  logic        rx_s_q,       rx_s_d;
  logic [14:0] div_q,        div_d;
  logic [14:0] tick_cnt_q,   tick_cnt_d;
  logic [3:0]  sample_cnt_q, sample_cnt_d;
  logic [2:0]  bit_cnt_q,    bit_cnt_d;
  logic [7:0]  shift_q,      shift_d;
  logic        perr_q,       perr_d;
  logic        stop_q,       stop_d;
  logic        wait_high_q,  wait_high_d;
  logic [7:0]  rx_data_q,    rx_data_d;
  logic        rx_valid_q,   rx_valid_d;
  logic        rx_perror_q,  rx_perror_d;
  logic        rx_ferror_q,  rx_ferror_d;

  logic [14:0] div_sel;
  logic        tick;

  // Divider selected by the live baud code; only captured at a start edge.
  always_comb begin
    div_sel = clamp_div(DIV_7);
    case (baud_select)
      3'b000:  div_sel = clamp_div(DIV_0);
      3'b001:  div_sel = clamp_div(DIV_1);
      3'b010:  div_sel = clamp_div(DIV_2);
      3'b011:  div_sel = clamp_div(DIV_3);
      3'b100:  div_sel = clamp_div(DIV_4);
      3'b101:  div_sel = clamp_div(DIV_5);
      3'b110:  div_sel = clamp_div(DIV_6);
      default: div_sel = clamp_div(DIV_7);
    endcase
  end

  // One-clock sample tick every div_q clocks while a frame is in progress.
  always_comb begin
    tick = (state_q != S_IDLE) && (tick_cnt_q >= (div_q - 15'd1));
  end

  // Next-state logic: synchroniser, tick counter, frame FSM and output update.
  always_comb begin
    rx_meta_d    = RxD;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    div_d        = div_q;
    tick_cnt_d   = tick_cnt_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    stop_d       = stop_q;
    wait_high_d  = wait_high_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_perror_d  = rx_perror_q;
    rx_ferror_d  = rx_ferror_q;

    // A line seen high ends any post-framing-error lockout.
    if (rx_s_q) begin
      wait_high_d = 1'b0;
    end

    if (state_q != S_IDLE) begin
      tick_cnt_d = tick ? 15'd0 : (tick_cnt_q + 15'd1);
    end

    if (!Rx_EN) begin
      // Disabled: drop any partial frame, outputs keep their values.
      state_d      = S_IDLE;
      tick_cnt_d   = 15'd0;
      sample_cnt_d = 4'd0;
      bit_cnt_d    = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!wait_high_q && !rx_s_q) begin
            state_d      = S_START;
            tick_cnt_d   = 15'd0;
            sample_cnt_d = 4'd0;
            bit_cnt_d    = 3'd0;
            div_d        = div_sel;
          end
        end

        S_START: begin
          if (tick) begin
            if (sample_cnt_q == START_MID) begin
              sample_cnt_d = 4'd0;
              if (rx_s_q) begin
                // Glitch shorter than half a bit: not a real start bit.
                state_d    = S_IDLE;
                tick_cnt_d = 15'd0;
              end else begin
                state_d = S_DATA;
              end
            end else begin
              sample_cnt_d = sample_cnt_q + 4'd1;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            if (sample_cnt_q == SAMPLE_LAST) begin
              sample_cnt_d       = 4'd0;
              shift_d[bit_cnt_q] = rx_s_q;
              if (bit_cnt_q == 3'd7) begin
                bit_cnt_d = 3'd0;
                state_d   = S_PARITY;
              end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
              end
            end else begin
              sample_cnt_d = sample_cnt_q + 4'd1;
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            if (sample_cnt_q == SAMPLE_LAST) begin
              sample_cnt_d = 4'd0;
              perr_d       = (^{shift_q, rx_s_q}) ^ ODD_FLIP;
              state_d      = S_STOP;
            end else begin
              sample_cnt_d = sample_cnt_q + 4'd1;
            end
          end
        end

        S_STOP: begin
          if (tick) begin
            if (sample_cnt_q == SAMPLE_LAST) begin
              sample_cnt_d = 4'd0;
              stop_d       = rx_s_q;
              state_d      = S_DONE;
            end else begin
              sample_cnt_d = sample_cnt_q + 4'd1;
            end
          end
        end

        S_DONE: begin
          rx_data_d    = shift_q;
          rx_perror_d  = perr_q;
          rx_ferror_d  = ~stop_q;
          rx_valid_d   = 1'b1;
          // A low stop bit means the line may still be held low (break).
          wait_high_d  = ~stop_q;
          state_d      = S_IDLE;
          tick_cnt_d   = 15'd0;
          sample_cnt_d = 4'd0;
          bit_cnt_d    = 3'd0;
        end

        default: begin
          state_d      = S_IDLE;
          tick_cnt_d   = 15'd0;
          sample_cnt_d = 4'd0;
          bit_cnt_d    = 3'd0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      div_q        <= 15'd1;
      tick_cnt_q   <= 15'd0;
      sample_cnt_q <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      perr_q       <= 1'b0;
      stop_q       <= 1'b1;
      wait_high_q  <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_perror_q  <= 1'b0;
      rx_ferror_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      div_q        <= div_d;
      tick_cnt_q   <= tick_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      stop_q       <= stop_d;
      wait_high_q  <= wait_high_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_perror_q  <= rx_perror_d;
      rx_ferror_q  <= rx_ferror_d;
    end
  end

  assign Rx_DATA   = rx_data_q;
  assign Rx_VALID  = rx_valid_q;
  assign Rx_PERROR = rx_perror_q;
  assign Rx_FERROR = rx_ferror_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver. The DUT is
//               built for a 10 MHz clock so frames stay short:
//               DIV(111) = 10921600/1843200 = 5  -> 80 clk/bit
//               DIV(011) = 10076800/153600  = 65 -> 1040 clk/bit
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int unsigned TB_CLK_FREQ = 10_000_000;
  localparam int B111 = 16 * 5;
  localparam int B011 = 16 * 65;

  logic       clk = 1'b0;
  logic       reset;
  logic       RxD;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ   (TB_CLK_FREQ),
    .OVERSAMPLE (16),
    .PARITY_EVEN(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .baud_select(baud_select),
    .Rx_EN      (Rx_EN),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_FERROR  (Rx_FERROR)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Record every valid pulse (sampled mid-cycle) with the byte and flags.
  int         vcount = 0;
  logic [7:0] cap_data [0:31];
  logic       cap_perr [0:31];
  logic       cap_ferr [0:31];

  always @(negedge clk) begin
    if (Rx_VALID === 1'b1) begin
      if (vcount < 32) begin
        cap_data[vcount] = Rx_DATA;
        cap_perr[vcount] = Rx_PERROR;
        cap_ferr[vcount] = Rx_FERROR;
      end
      vcount = vcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int clks);
    RxD = v;
    repeat (clks) @(negedge clk);
  endtask

  // Even-parity frame; flip_par corrupts parity, stop_v sets the stop bit.
  // The line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input int bclk,
                            input logic flip_par, input logic stop_v,
                            input logic glitch);
    logic       par;
    logic [2:0] saved;
    par   = (^d) ^ flip_par;
    saved = baud_select;
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) begin
      if (glitch && i == 3) baud_select = ~saved;
      drive_bit(d[i], bclk);
    end
    if (glitch) baud_select = saved;
    drive_bit(par, bclk);
    drive_bit(stop_v, bclk);
  endtask

  // Start bit, data bits 0..3 and half of bit 4 of a frame.
  task automatic send_partial(input logic [7:0] d, input int bclk);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 4; i++) drive_bit(d[i], bclk);
    drive_bit(d[4], bclk / 2);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    RxD         = 1'b1;
    Rx_EN       = 1'b1;
    baud_select = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_data",  {24'd0, Rx_DATA}, 32'h00);
    chk("reset_valid", {31'd0, Rx_VALID}, 32'd0);
    chk("reset_perr",  {31'd0, Rx_PERROR}, 32'd0);
    chk("reset_ferr",  {31'd0, Rx_FERROR}, 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: single clean frame at code 111
    send_frame(8'hAA, B111, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t1_count", vcount, 1);
    chk("t1_data",  {24'd0, cap_data[0]}, 32'hAA);
    chk("t1_perr",  {31'd0, cap_perr[0]}, 32'd0);
    chk("t1_ferr",  {31'd0, cap_ferr[0]}, 32'd0);
    chk("t1_hold",  {24'd0, Rx_DATA}, 32'hAA);

    // 2: three back-to-back frames at code 011, baud code disturbed mid-frame
    baud_select = 3'b011;
    send_frame(8'h55, B011, 1'b0, 1'b1, 1'b1);
    send_frame(8'hCC, B011, 1'b0, 1'b1, 1'b0);
    send_frame(8'h89, B011, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t2_count", vcount, 4);
    chk("t2_data0", {24'd0, cap_data[1]}, 32'h55);
    chk("t2_data1", {24'd0, cap_data[2]}, 32'hCC);
    chk("t2_data2", {24'd0, cap_data[3]}, 32'h89);
    chk("t2_flags", {26'd0, cap_perr[1], cap_perr[2], cap_perr[3],
                     cap_ferr[1], cap_ferr[2], cap_ferr[3]}, 32'd0);

    // 3: parity error on 0x89, then a clean frame clears it
    baud_select = 3'b111;
    repeat (10) @(negedge clk);
    send_frame(8'h89, B111, 1'b1, 1'b1, 1'b0);
    repeat (50) @(negedge clk);
    chk("t3_count", vcount, 5);
    chk("t3_data",  {24'd0, cap_data[4]}, 32'h89);
    chk("t3_perr",  {31'd0, cap_perr[4]}, 32'd1);
    chk("t3_ferr",  {31'd0, cap_ferr[4]}, 32'd0);
    chk("t3_perr_hold", {31'd0, Rx_PERROR}, 32'd1);
    send_frame(8'h55, B111, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t3_clean_count", vcount, 6);
    chk("t3_clean_data",  {24'd0, cap_data[5]}, 32'h55);
    chk("t3_clean_perr",  {31'd0, cap_perr[5]}, 32'd0);

    // 4: framing error, line then held low for a long time
    send_frame(8'hCC, B111, 1'b0, 1'b0, 1'b0);
    repeat (2000) @(negedge clk);
    chk("t4_count", vcount, 7);
    chk("t4_data",  {24'd0, cap_data[6]}, 32'hCC);
    chk("t4_perr",  {31'd0, cap_perr[6]}, 32'd0);
    chk("t4_ferr",  {31'd0, cap_ferr[6]}, 32'd1);
    chk("t4_ferr_hold", {31'd0, Rx_FERROR}, 32'd1);
    drive_bit(1'b1, 2 * B111);
    send_frame(8'hAA, B111, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t4_next_count", vcount, 8);
    chk("t4_next_data",  {24'd0, cap_data[7]}, 32'hAA);
    chk("t4_next_ferr",  {31'd0, cap_ferr[7]}, 32'd0);

    // 5: false start of 4 ticks
    drive_bit(1'b0, 4 * 5);
    drive_bit(1'b1, 300);
    chk("t5_no_valid", vcount, 8);
    send_frame(8'hAA, B111, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t5_count", vcount, 9);
    chk("t5_data",  {24'd0, cap_data[8]}, 32'hAA);

    // 6a: reset during data bit 4 of 0x55
    send_partial(8'h55, B111);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_bit(1'b1, 12 * B111);
    chk("t6a_no_valid", vcount, 9);
    chk("t6a_data",  {24'd0, Rx_DATA}, 32'h00);
    chk("t6a_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);
    send_frame(8'hAA, B111, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t6a_count", vcount, 10);
    chk("t6a_next",  {24'd0, cap_data[9]}, 32'hAA);

    // 6b: receiver disabled during data bit 4 of 0x55
    send_partial(8'h55, B111);
    Rx_EN = 1'b0;
    repeat (5) @(negedge clk);
    Rx_EN = 1'b1;
    drive_bit(1'b1, 12 * B111);
    chk("t6b_no_valid", vcount, 10);
    chk("t6b_data_hold", {24'd0, Rx_DATA}, 32'hAA);
    chk("t6b_flags", {30'd0, Rx_PERROR, Rx_FERROR}, 32'd0);
    send_frame(8'hAA, B111, 1'b0, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    chk("t6b_count", vcount, 11);
    chk("t6b_next",  {24'd0, cap_data[10]}, 32'hAA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
